// File: rtl/and4_exerciser_if.sv
// Signal bundle between the AND4 exerciser and its harness: run control,
// the four cell drives with the cell response, and the run results.
interface and4_exerciser_if #(
    parameter int CNT_W = 16
);
    logic             START;
    logic             ABORT;
    logic             Q_IN;
    logic             IN1;
    logic             IN2;
    logic             IN3;
    logic             IN4;
    logic             BUSY;
    logic             DONE;
    logic [CNT_W-1:0] ERR_CNT;
    logic [CNT_W-1:0] TOG_CNT;
    logic             FAIL_VLD;
    logic [3:0]       FAIL_VEC;

    // Harness side: requests runs and models the cell under test.
    modport master (
        output START, ABORT, Q_IN,
        input  IN1, IN2, IN3, IN4, BUSY, DONE, ERR_CNT, TOG_CNT, FAIL_VLD, FAIL_VEC
    );

    // Exerciser side.
    modport slave (
        input  START, ABORT, Q_IN,
        output IN1, IN2, IN3, IN4, BUSY, DONE, ERR_CNT, TOG_CNT, FAIL_VLD, FAIL_VEC
    );
endinterface

// File: rtl/and4_exerciser.sv
// Gray-code stimulus driver and response checker for a 4-input AND cell:
// one input changes per step, Q is sampled after a settle window and scored.
module and4_exerciser #(
    parameter int SETTLE_CYCLES = 2,
    parameter int REPEAT        = 1,
    parameter int CNT_W         = 16
) (
    input  logic CLK,
    input  logic RSTB,
    and4_exerciser_if.slave bus
);

    localparam logic [7:0] LAST_SETTLE = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] LAST_PASS   = 8'(REPEAT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        FIN    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [3:0]       step_q, step_d;
    logic [7:0]       pass_q, pass_d;
    logic [3:0]       drv_q, drv_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [CNT_W-1:0] tog_q, tog_d;
    logic             fvld_q, fvld_d;
    logic [3:0]       fvec_q, fvec_d;
    logic             base_q, base_d;
    logic             prev_q, prev_d;
    logic             mismatch;
    logic             changed;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [3:0] gray(input logic [3:0] n);
        return n ^ (n >> 1);
    endfunction

    // Case-inequality so an X/Z response from the cell is scored as a failure.
    assign mismatch = (bus.Q_IN !== (&drv_q));
    assign changed  = (bus.Q_IN !== prev_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        pass_d  = pass_q;
        drv_d   = drv_q;
        done_d  = 1'b0;
        err_d   = err_q;
        tog_d   = tog_q;
        fvld_d  = fvld_q;
        fvec_d  = fvec_q;
        base_d  = base_q;
        prev_d  = prev_q;

        unique case (state_q)
            IDLE: begin
                if (bus.START && !bus.ABORT) begin
                    err_d   = '0;
                    tog_d   = '0;
                    fvld_d  = 1'b0;
                    fvec_d  = 4'd0;
                    step_d  = 4'd0;
                    pass_d  = 8'd0;
                    cnt_d   = 8'd0;
                    base_d  = 1'b0;
                    drv_d   = gray(4'd0);
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (bus.ABORT) begin
                    drv_d   = 4'd0;
                    cnt_d   = 8'd0;
                    state_d = IDLE;
                end else if (cnt_q == LAST_SETTLE) begin
                    cnt_d   = 8'd0;
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            SAMPLE: begin
                if (bus.ABORT) begin
                    drv_d   = 4'd0;
                    state_d = IDLE;
                end else begin
                    if (mismatch) begin
                        err_d = sat_inc(err_q);
                        if (!fvld_q) begin
                            fvld_d = 1'b1;
                            fvec_d = drv_q;
                        end
                    end
                    // The first sample of a run is only the toggle baseline.
                    if (base_q && changed) begin
                        tog_d = sat_inc(tog_q);
                    end
                    prev_d = bus.Q_IN;
                    base_d = 1'b1;
                    if (step_q == 4'd15 && pass_q == LAST_PASS) begin
                        drv_d   = 4'd0;
                        done_d  = 1'b1;
                        state_d = FIN;
                    end else begin
                        step_d  = step_q + 4'd1;
                        if (step_q == 4'd15) begin
                            pass_d = pass_q + 8'd1;
                        end
                        drv_d   = gray(step_q + 4'd1);
                        state_d = SETTLE;
                    end
                end
            end
            FIN: begin
                drv_d   = 4'd0;
                state_d = IDLE;
            end
            default: begin
                drv_d   = 4'd0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            step_q  <= 4'd0;
            pass_q  <= 8'd0;
            drv_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= '0;
            tog_q   <= '0;
            fvld_q  <= 1'b0;
            fvec_q  <= 4'd0;
            base_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            pass_q  <= pass_d;
            drv_q   <= drv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            tog_q   <= tog_d;
            fvld_q  <= fvld_d;
            fvec_q  <= fvec_d;
            base_q  <= base_d;
        end
    end

    // Previous-sample holder needs no reset: base_q gates every use of it.
    always_ff @(posedge CLK) begin
        prev_q <= prev_d;
    end

    assign bus.IN1      = drv_q[0];
    assign bus.IN2      = drv_q[1];
    assign bus.IN3      = drv_q[2];
    assign bus.IN4      = drv_q[3];
    assign bus.BUSY     = busy_q;
    assign bus.DONE     = done_q;
    assign bus.ERR_CNT  = err_q;
    assign bus.TOG_CNT  = tog_q;
    assign bus.FAIL_VLD = fvld_q;
    assign bus.FAIL_VEC = fvec_q;

endmodule

// File: tb/tb_and4_exerciser.sv
// Directed bench for and4_exerciser: two instances (REPEAT=1 and REPEAT=3)
// driven against golden, stuck-at-0 and stuck-at-1 cell models.
module tb_and4_exerciser;

    localparam int CNT_W = 16;

    logic CLK  = 1'b0;
    logic RSTB = 1'b1;
    logic go   = 1'b0;
    logic stop = 1'b0;
    int   sel  = 0;
    int   mode = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc;

    always #5 CLK = ~CLK;

    and4_exerciser_if #(.CNT_W(CNT_W)) ifa ();
    and4_exerciser_if #(.CNT_W(CNT_W)) ifb ();

    and4_exerciser #(.SETTLE_CYCLES(2), .REPEAT(1), .CNT_W(CNT_W)) dut_a (
        .CLK (CLK),
        .RSTB(RSTB),
        .bus (ifa.slave)
    );

    and4_exerciser #(.SETTLE_CYCLES(2), .REPEAT(3), .CNT_W(CNT_W)) dut_b (
        .CLK (CLK),
        .RSTB(RSTB),
        .bus (ifb.slave)
    );

    // Cell model: 0 = golden AND4, 1 = stuck at 0, 2 = stuck at 1.
    function automatic logic qmodel(input int m, input logic [3:0] d);
        case (m)
            1:       return 1'b0;
            2:       return 1'b1;
            default: return &d;
        endcase
    endfunction

    function automatic logic [3:0] gray4(input int n);
        logic [3:0] v;
        v = 4'(n);
        return v ^ (v >> 1);
    endfunction

    assign ifa.START = go && (sel == 0);
    assign ifb.START = go && (sel == 1);
    assign ifa.ABORT = stop && (sel == 0);
    assign ifb.ABORT = stop && (sel == 1);
    assign ifa.Q_IN  = qmodel(mode, {ifa.IN4, ifa.IN3, ifa.IN2, ifa.IN1});
    assign ifb.Q_IN  = qmodel(mode, {ifb.IN4, ifb.IN3, ifb.IN2, ifb.IN1});

    logic [3:0]       drv;
    logic             busy;
    logic             done;
    logic             fvld;
    logic [3:0]       fvec;
    logic [CNT_W-1:0] err;
    logic [CNT_W-1:0] tog;

    always_comb begin
        if (sel == 0) begin
            drv  = {ifa.IN4, ifa.IN3, ifa.IN2, ifa.IN1};
            busy = ifa.BUSY;
            done = ifa.DONE;
            fvld = ifa.FAIL_VLD;
            fvec = ifa.FAIL_VEC;
            err  = ifa.ERR_CNT;
            tog  = ifa.TOG_CNT;
        end else begin
            drv  = {ifb.IN4, ifb.IN3, ifb.IN2, ifb.IN1};
            busy = ifb.BUSY;
            done = ifb.DONE;
            fvld = ifb.FAIL_VLD;
            fvec = ifb.FAIL_VEC;
            err  = ifb.ERR_CNT;
            tog  = ifb.TOG_CNT;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_drv"},  int'(drv),  0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_err"},  int'(err),  0);
        chk({tag, "_tog"},  int'(tog),  0);
        chk({tag, "_fvld"}, int'(fvld), 0);
        chk({tag, "_fvec"}, int'(fvec), 0);
    endtask

    // One full run: counts busy cycles before DONE, checks the Gray walk,
    // and optionally pulses START mid-run (must be ignored).
    task automatic run(input int nsteps, input bit poke, output int ncyc);
        int  bad;
        bit  seen;
        bad  = 0;
        seen = 1'b0;
        ncyc = 0;
        @(negedge CLK);
        go = 1'b1;
        @(negedge CLK);
        go = 1'b0;
        for (int k = 0; k < nsteps * 3 + 20; k++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (!busy) bad++;
            if (drv !== gray4((ncyc / 3) % 16)) bad++;
            go = poke && (ncyc == 20 || ncyc == 100);
            ncyc++;
            @(negedge CLK);
        end
        go = 1'b0;
        chk("done_seen", int'(seen), 1);
        chk("gray_walk", bad, 0);
        chk("fin_drv",   int'(drv),  0);
        chk("fin_busy",  int'(busy), 1);
        @(negedge CLK);
        chk("post_busy", int'(busy), 0);
        chk("post_done", int'(done), 0);
    endtask

    initial begin
        int dseen;
        // Reset state.
        #3 RSTB = 1'b0;
        #1;
        check_idle_zero("reset");
        repeat (3) @(negedge CLK);
        RSTB = 1'b1;

        // Golden model, REPEAT=1.
        sel = 0; mode = 0;
        run(16, 1'b0, cyc);
        chk("gold_cycles", cyc, 48);
        chk("gold_err",  int'(err),  0);
        chk("gold_tog",  int'(tog),  2);
        chk("gold_fvld", int'(fvld), 0);

        // Stuck at 0.
        mode = 1;
        run(16, 1'b0, cyc);
        chk("s0_err",  int'(err),  1);
        chk("s0_fvld", int'(fvld), 1);
        chk("s0_fvec", int'(fvec), 15);
        chk("s0_tog",  int'(tog),  0);

        // Stuck at 1.
        mode = 2;
        run(16, 1'b0, cyc);
        chk("s1_err",  int'(err),  15);
        chk("s1_fvld", int'(fvld), 1);
        chk("s1_fvec", int'(fvec), 0);
        chk("s1_tog",  int'(tog),  0);
        repeat (4) @(negedge CLK);
        chk("s1_hold_err", int'(err), 15);

        // REPEAT=3 with START pokes during BUSY.
        sel = 1; mode = 0;
        run(48, 1'b1, cyc);
        chk("rep3_cycles", cyc, 144);
        chk("rep3_tog",  int'(tog), 6);
        chk("rep3_err",  int'(err), 0);
        repeat (3) @(negedge CLK);
        chk("rep3_no_restart", int'(busy), 0);

        // Abort at step 11 of a stuck-at-0 run.
        sel = 0; mode = 1;
        @(negedge CLK);
        go = 1'b1;
        @(negedge CLK);
        go = 1'b0;
        repeat (33) @(negedge CLK);
        chk("abort_at_step11", int'(drv), 4'b1110);
        stop = 1'b1;
        @(negedge CLK);
        stop = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_drv",  int'(drv),  0);
        chk("abort_done", int'(done), 0);
        chk("abort_err",  int'(err),  1);
        dseen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            if (done || busy) dseen++;
        end
        chk("abort_quiet", dseen, 0);
        chk("abort_hold_fvec", int'(fvec), 15);

        // Restart clears counters, then async reset mid-SETTLE.
        mode = 2;
        go = 1'b1;
        @(negedge CLK);
        go = 1'b0;
        chk("restart_err",  int'(err),  0);
        chk("restart_busy", int'(busy), 1);
        repeat (7) @(negedge CLK);
        chk("midrun_err", int'(err), 2);
        chk("midrun_drv", int'(drv), 4'b0011);
        #2 RSTB = 1'b0;
        #1;
        check_idle_zero("async_rst");
        @(negedge CLK);
        RSTB = 1'b1;
        mode = 0;
        run(16, 1'b0, cyc);
        chk("after_rst_cycles", cyc, 48);
        chk("after_rst_err", int'(err), 0);
        chk("after_rst_tog", int'(tog), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
